fc_tx_scheduler: RTL and testbench



---
 rtl/fc_pkg.sv | 23 ++
 rtl/rr_arbiter4.sv | 35 +++
 rtl/fc_tx_scheduler.sv | 160 ++++++++++++++++
 tb/tb_fc_tx_scheduler.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// fc_pkg: shared definitions for the flow-control transmit path.
//   FC_NUM_CH      - channel count, fixed at 4 to match the flow-control vectors
//   FC_DATA_WIDTH  - default data word width
//   ST_*           - bit positions of the one-hot scheduler states
//   fc_state_t     - one-hot scheduler state encoding
package fc_pkg;

  localparam int unsigned FC_NUM_CH     = 4;
  localparam int unsigned FC_DATA_WIDTH = 8;

  localparam int unsigned ST_RESET = 0;
  localparam int unsigned ST_INIT  = 1;
  localparam int unsigned ST_RUN   = 2;
  localparam int unsigned ST_HALT  = 3;

  typedef enum logic [3:0] {
    S_RESET = 4'b0001,
    S_INIT  = 4'b0010,
    S_RUN   = 4'b0100,
    S_HALT  = 4'b1000
  } fc_state_t;

endpackage

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: purely combinational 4-way round-robin arbiter.
// The search starts at i_ptr and wraps 3 -> 0; the first requester found wins.
//   i_req      - request vector
//   i_ptr      - highest-priority index for this cycle
//   o_gnt      - one-hot grant (all zero when nothing requests)
//   o_gnt_idx  - index of the granted requester (0 when nothing requests)
//   o_gnt_any  - high when some requester was granted
module rr_arbiter4 (
  input  logic [3:0] i_req,
  input  logic [1:0] i_ptr,
  output logic [3:0] o_gnt,
  output logic [1:0] o_gnt_idx,
  output logic       o_gnt_any
);

  logic [1:0] w_idx;

  always_comb begin
    o_gnt     = 4'b0000;
    o_gnt_idx = 2'd0;
    o_gnt_any = 1'b0;
    w_idx     = 2'd0;
    // Walk from the farthest offset down to offset 0 so the nearest requester
    // to the pointer is the one left standing.
    for (int k = 3; k >= 0; k--) begin
      w_idx = i_ptr + 2'(k);
      if (i_req[w_idx]) begin
        o_gnt     = 4'b0001 << w_idx;
        o_gnt_idx = w_idx;
        o_gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fc_tx_scheduler.sv
// fc_tx_scheduler: upstream transmitter of the flow-control path.
// Moves one word per cycle, round-robin, from 4 source channels into 4 downstream
// virtual-channel FIFOs, honouring per-channel pause/continue/idle and halting for
// good on any downstream overflow until reset.
// Optional feature macro: FC_PAUSE_TIMEOUT_EN (paused channels auto-resume after
// PAUSE_TIMEOUT paused cycles, guarding against a lost continuar).
// Ports:
//   clk, rst         - clock; synchronous active-high reset
//   i_enb            - global enable; low freezes state and blocks grants
//   i_iniciar        - leave INIT and start scheduling
//   i_pausa          - per-channel pause request
//   i_continuar      - per-channel resume request
//   i_error_full     - per-channel downstream overflow; any bit halts
//   i_idle           - downstream idle; resumes all channels
//   i_src_valid      - per-source word available
//   i_src_data       - source words, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   o_src_ready      - combinational one-hot grant
//   o_push           - registered one-hot FIFO write strobe
//   o_data_out       - registered word accompanying o_push
//   o_paused         - registered per-channel pause state
//   o_halted         - registered, high in HALT
module fc_tx_scheduler
  import fc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = FC_DATA_WIDTH,
  parameter int unsigned NUM_CH        = FC_NUM_CH,
  parameter int unsigned PAUSE_TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_enb,
  input  logic                         i_iniciar,
  input  logic [NUM_CH-1:0]            i_pausa,
  input  logic [NUM_CH-1:0]            i_continuar,
  input  logic [NUM_CH-1:0]            i_error_full,
  input  logic                         i_idle,
  input  logic [NUM_CH-1:0]            i_src_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] i_src_data,
  output logic [NUM_CH-1:0]            o_src_ready,
  output logic [NUM_CH-1:0]            o_push,
  output logic [DATA_WIDTH-1:0]        o_data_out,
  output logic [NUM_CH-1:0]            o_paused,
  output logic                         o_halted
);

  fc_state_t             r_state;
  logic [NUM_CH-1:0]     r_push;
  logic [NUM_CH-1:0]     r_paused;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_halted;
  logic [1:0]            r_rr;

  logic                  w_run;
  logic                  w_err;
  logic [NUM_CH-1:0]     w_eligible;
  logic [NUM_CH-1:0]     w_gnt;
  logic [1:0]            w_gnt_idx;
  logic                  w_gnt_any;
  logic [NUM_CH-1:0]     w_timeout;
  logic [NUM_CH-1:0]     w_paused_nxt;

  assign w_run = (r_state == S_RUN);
  assign w_err = |i_error_full;

  // Overflow masks grants in the very cycle it is seen, before HALT is reached.
  assign w_eligible = i_src_valid & ~r_paused & {NUM_CH{w_run & i_enb & ~w_err}};

  rr_arbiter4 u_arb (
    .i_req     (w_eligible),
    .i_ptr     (r_rr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_gnt_any (w_gnt_any)
  );

`ifdef FC_PAUSE_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(PAUSE_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(PAUSE_TIMEOUT);

  logic [CntW-1:0] r_pcnt [NUM_CH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) r_pcnt[i] <= '0;
    end else if (i_enb && w_run) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (i_pausa[i]) begin
          r_pcnt[i] <= '0;
        end else if (r_paused[i] && (r_pcnt[i] != CntMax)) begin
          r_pcnt[i] <= r_pcnt[i] + CntW'(1);
        end
      end
    end
  end

  always_comb begin
    w_timeout = '0;
    for (int i = 0; i < NUM_CH; i++) w_timeout[i] = r_paused[i] && (r_pcnt[i] == CntMax);
  end
`else
  assign w_timeout = '0;
`endif

  // pausa dominates both continuar and idle on the same channel.
  always_comb begin
    w_paused_nxt = r_paused;
    for (int i = 0; i < NUM_CH; i++) begin
      if (i_pausa[i]) begin
        w_paused_nxt[i] = 1'b1;
      end else if (i_continuar[i] || i_idle || w_timeout[i]) begin
        w_paused_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_RESET;
      r_push   <= '0;
      r_data   <= '0;
      r_paused <= '0;
      r_halted <= 1'b0;
      r_rr     <= 2'd0;
    end else begin
      // Grant only exists when enabled in RUN, so acceptance needs no extra gating.
      r_push <= '0;
      if (w_gnt_any) begin
        r_push <= w_gnt;
        r_data <= i_src_data[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH];
        r_rr   <= w_gnt_idx + 2'd1;
      end
      unique case (r_state)
        S_RESET: r_state <= S_INIT;
        S_INIT: begin
          if (i_enb && i_iniciar) r_state <= S_RUN;
        end
        S_RUN: begin
          if (i_enb) begin
            if (w_err) begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
              r_paused <= '0;
            end else begin
              r_paused <= w_paused_nxt;
            end
          end
        end
        S_HALT: r_halted <= 1'b1;
        default: r_state <= S_RESET;
      endcase
    end
  end

  assign o_src_ready = w_gnt;
  assign o_push      = r_push;
  assign o_data_out  = r_data;
  assign o_paused    = r_paused;
  assign o_halted    = r_halted;

endmodule

// File: tb/tb_fc_tx_scheduler.sv
// Directed bench for fc_tx_scheduler: hand-computed push/grant/pause sequences
// covering rotation, pause/continue/idle priority, enable freeze, halt and reset.
module tb_fc_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        enb;
  logic        iniciar;
  logic [3:0]  pausa;
  logic [3:0]  continuar;
  logic [3:0]  error_full;
  logic        idle;
  logic [3:0]  src_valid;
  logic [31:0] src_data;
  logic [3:0]  src_ready;
  logic [3:0]  push;
  logic [7:0]  data_out;
  logic [3:0]  paused;
  logic        halted;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  fc_tx_scheduler #(
    .DATA_WIDTH    (8),
    .NUM_CH        (4),
    .PAUSE_TIMEOUT (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_enb        (enb),
    .i_iniciar    (iniciar),
    .i_pausa      (pausa),
    .i_continuar  (continuar),
    .i_error_full (error_full),
    .i_idle       (idle),
    .i_src_valid  (src_valid),
    .i_src_data   (src_data),
    .o_src_ready  (src_ready),
    .o_push       (push),
    .o_data_out   (data_out),
    .o_paused     (paused),
    .o_halted     (halted)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] exp_oh;
    rst        = 1'b1;
    enb        = 1'b1;
    iniciar    = 1'b0;
    pausa      = 4'b0000;
    continuar  = 4'b0000;
    error_full = 4'b0000;
    idle       = 1'b0;
    src_valid  = 4'b1111;
    src_data   = 32'hA3A2A1A0;

    // Reset state
    tick();
    tick();
    chk("rst_push",   32'(push),      32'h0);
    chk("rst_data",   32'(data_out),  32'h0);
    chk("rst_paused", 32'(paused),    32'h0);
    chk("rst_halted", 32'(halted),    32'h0);
    chk("rst_ready",  32'(src_ready), 32'h0);

    // RESET -> INIT: still no grants
    rst = 1'b0;
    tick();
    chk("init_ready", 32'(src_ready), 32'h0);
    tick();
    chk("init_hold_ready", 32'(src_ready), 32'h0);

    // INIT -> RUN; first grant visible now, push one cycle later
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    #1;
    chk("run_first_ready", 32'(src_ready), 32'h1);
    chk("run_first_push",  32'(push),      32'h0);

    // Test 1: rotation 0,1,2,3,0,1
    for (int k = 0; k < 6; k++) begin
      tick();
      exp_oh = 4'b0001 << (k % 4);
      chk($sformatf("rot_push_%0d", k), 32'(push),     32'(exp_oh));
      chk($sformatf("rot_data_%0d", k), 32'(data_out), 32'(8'hA0 + 8'(k % 4)));
    end
    chk("rot_ready_after", 32'(src_ready), 32'h4);

    // Test 2: pause channel 2 in the cycle it is granted; word still pushed
    pausa = 4'b0100;
    tick();
    pausa = 4'b0000;
    chk("p2_push_same",  32'(push),   32'h4);
    chk("p2_paused",     32'(paused), 32'h4);
    tick(); chk("p2_push_a", 32'(push), 32'h8);
    tick(); chk("p2_push_b", 32'(push), 32'h1);
    tick(); chk("p2_push_c", 32'(push), 32'h2);
    tick(); chk("p2_push_d", 32'(push), 32'h8);
    tick(); chk("p2_push_e", 32'(push), 32'h1);
    continuar = 4'b0100;
    tick();
    continuar = 4'b0000;
    chk("p2_cont_push",   32'(push),   32'h2);
    chk("p2_cont_paused", 32'(paused), 32'h0);
    tick(); chk("p2_resumed_push", 32'(push), 32'h4);

    // Test 3: pausa beats continuar; pausa beats idle; idle alone clears
    pausa     = 4'b0010;
    continuar = 4'b0010;
    tick();
    chk("pc_paused", 32'(paused), 32'h2);
    chk("pc_push",   32'(push),   32'h8);
    pausa     = 4'b0001;
    continuar = 4'b0000;
    idle      = 1'b1;
    tick();
    chk("pi_paused", 32'(paused), 32'h1);
    chk("pi_push",   32'(push),   32'h1);
    pausa = 4'b0000;
    tick();
    idle = 1'b0;
    chk("idle_paused", 32'(paused), 32'h0);
    chk("idle_push",   32'(push),   32'h2);

    // Test 5: enable low freezes pointer and pause state
    enb   = 1'b0;
    pausa = 4'b0001;
    #1;
    chk("enb_ready", 32'(src_ready), 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("enb_push_%0d", k), 32'(push), 32'h0);
    end
    chk("enb_paused", 32'(paused), 32'h0);
    pausa = 4'b0000;
    enb   = 1'b1;
    #1;
    chk("enb_resume_ready", 32'(src_ready), 32'h4);
    tick(); chk("enb_resume_push", 32'(push), 32'h4);

    // Test 4: overflow masks grant at once, then halts
    pausa = 4'b1000;
    tick();
    pausa = 4'b0000;
    chk("pre_halt_push",   32'(push),   32'h8);
    chk("pre_halt_paused", 32'(paused), 32'h8);
    error_full = 4'b0001;
    #1;
    chk("err_ready", 32'(src_ready), 32'h0);
    tick();
    error_full = 4'b0000;
    chk("halt_halted", 32'(halted),   32'h1);
    chk("halt_push",   32'(push),     32'h0);
    chk("halt_paused", 32'(paused),   32'h0);
    chk("halt_data",   32'(data_out), 32'hA3);
    pausa = 4'b1111;
    tick();
    pausa     = 4'b0000;
    continuar = 4'b1111;
    tick();
    continuar = 4'b0000;
    chk("halt_sticky",        32'(halted),    32'h1);
    chk("halt_ignore_pause",  32'(paused),    32'h0);
    chk("halt_ready",         32'(src_ready), 32'h0);
    rst = 1'b1;
    tick();
    chk("rst2_halted", 32'(halted),    32'h0);
    chk("rst2_push",   32'(push),      32'h0);
    chk("rst2_data",   32'(data_out),  32'h0);
    chk("rst2_ready",  32'(src_ready), 32'h0);

    // Test 6: pause with no continuar
    rst       = 1'b0;
    src_valid = 4'b0000;
    tick();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    pausa   = 4'b1000;
    tick();
    pausa = 4'b0000;
    chk("to_paused_set", 32'(paused), 32'h8);
`ifdef FC_PAUSE_TIMEOUT_EN
    repeat (8) tick();
    chk("to_still_paused", 32'(paused), 32'h8);
    tick();
    chk("to_cleared", 32'(paused), 32'h0);
`else
    repeat (100) tick();
    chk("to_stays_paused", 32'(paused), 32'h8);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
